paralelo_serial_tx: RTL and testbench

Transmit-side parallel-to-serial stage that feeds the lane's serial-to-parallel receiver. It accepts bytes through a valid/ready handshake into a small FIFO and serialises them MSB-first at the bit clock. After reset it sends a training burst of 0xBC comma bytes so the receiver can align. Whenever no data is queued it fills the line with 0xBC idle bytes.

---
 rtl/paralelo_serial_tx.sv | 96 +++++++++
 tb/tb_paralelo_serial_tx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/paralelo_serial_tx.sv
// Byte FIFO feeding an MSB-first serialiser on clk_8f: TRAIN_BYTES comma bytes after
// reset, then queued data, with IDLE_BYTE filling every gap in the line.
module paralelo_serial_tx #(
  parameter int         DEPTH       = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hBC,
  parameter int         TRAIN_BYTES = 4
) (
  input  logic       clk_8f,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TRAIN_BYTES + 1);

  typedef enum logic {ST_TRAIN = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] train_q, train_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic load, push, pop, fifo_empty, train_last;

  assign load       = (bit_cnt_q == 3'd7);
  assign fifo_empty = (count_q == '0);
  assign ready_out  = reset_L && (count_q < CW'(DEPTH));
  assign push       = valid_in && ready_out;
  assign train_last = (train_q == TW'(TRAIN_BYTES - 1));
  assign data_out   = shift_q[7];

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) state_q <= ST_TRAIN;
    else          state_q <= state_d;
  end

  // ACTIVE is sticky; only reset returns the block to training.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_TRAIN && load && train_last) state_d = ST_ACTIVE;
  end

  always_comb begin
    active_out = (state_q == ST_ACTIVE);
    pop        = 1'b0;
    train_d    = train_q;
    case (state_q)
      ST_TRAIN:  if (load) train_d = train_q + TW'(1);
      ST_ACTIVE: pop = load && !fifo_empty;
      default:   ;
    endcase
  end

  // Pop decision uses the count from before this edge, so a byte pushed on a
  // load edge into an empty FIFO waits for the next load.
  always_comb begin
    shift_d = {shift_q[6:0], 1'b0};
    if (load) shift_d = pop ? mem_q[rd_ptr_q] : IDLE_BYTE;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt_q <= 3'd7;
      shift_q   <= '0;
      train_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= shift_d;
      train_q   <= train_d;
      count_q   <= count_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk_8f) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: directed vector table plus random traffic, both
// checked every cycle against a queue-based model of the serial line.
module tb_paralelo_serial_tx;
  localparam int         DEPTH = 4;
  localparam logic [7:0] IDLE  = 8'hBC;
  localparam int         TRAIN = 4;

  logic       clk_8f = 1'b0;
  logic       reset_L;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out, data_out, active_out;

  paralelo_serial_tx #(.DEPTH(DEPTH), .IDLE_BYTE(IDLE), .TRAIN_BYTES(TRAIN)) dut (
    .clk_8f    (clk_8f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .active_out(active_out)
  );

  always #5 clk_8f = ~clk_8f;

  typedef enum int {K_PUSH, K_RDY, K_ACT, K_BYTE} kind_e;
  typedef struct {
    int         run;
    int         edge_no;
    kind_e      kind;
    logic [7:0] val;
  } vec_t;

  vec_t       vecs[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  // Reference model: edge count since release, byte queue, current line byte.
  logic [7:0] mq[$];
  int         m_n, m_loads;
  logic [7:0] m_cur;

  logic [7:0] upq[$];
  logic [7:0] pend_byte;
  int         pend_left;

  function automatic void add(int r, int e, kind_e k, logic [7:0] v);
    vec_t t;
    t.run = r; t.edge_no = e; t.kind = k; t.val = v;
    vecs.push_back(t);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", nm, m_n, act, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_n = 0; m_loads = 0; m_cur = 8'h00;
  endtask

  task automatic tick(input logic v, input logic [7:0] d, output logic acc);
    logic rdy_m;
    int   ph;
    valid_in = v;
    data_in  = d;
    rdy_m = (mq.size() < DEPTH);
    @(posedge clk_8f);
    m_n++;
    ph = (m_n - 1) % 8;
    if (ph == 0) begin
      if (m_loads < TRAIN)     m_cur = IDLE;
      else if (mq.size() != 0) m_cur = mq.pop_front();
      else                     m_cur = IDLE;
      m_loads++;
    end
    acc = v && rdy_m;
    if (acc) mq.push_back(d);
    #1;
    chk("model_data_out", {7'd0, data_out}, {7'd0, m_cur[7-ph]});
    chk("model_ready_out", {7'd0, ready_out}, {7'd0, (mq.size() < DEPTH)});
    chk("model_active_out", {7'd0, active_out}, {7'd0, (m_loads >= TRAIN)});
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    data_in  = 8'h00;
    reset_L  = 1'b0;
    #1;
    chk("rst_data_out", {7'd0, data_out}, 8'h00);
    chk("rst_ready_out", {7'd0, ready_out}, 8'h00);
    chk("rst_active_out", {7'd0, active_out}, 8'h00);
    repeat (2) @(posedge clk_8f);
    @(negedge clk_8f);
    chk("rst_hold_data_out", {7'd0, data_out}, 8'h00);
    reset_L = 1'b1;
    m_reset();
    #1;
    chk("rel_data_out", {7'd0, data_out}, 8'h00);
    chk("rel_ready_out", {7'd0, ready_out}, 8'h01);
    chk("rel_active_out", {7'd0, active_out}, 8'h00);
  endtask

  task automatic check_recs(int id, int e);
    foreach (vecs[i]) begin
      if (vecs[i].run == id && vecs[i].edge_no == e) begin
        case (vecs[i].kind)
          K_RDY:  chk("tbl_ready_out", {7'd0, ready_out}, vecs[i].val);
          K_ACT:  chk("tbl_active_out", {7'd0, active_out}, vecs[i].val);
          K_BYTE: begin pend_byte = vecs[i].val; pend_left = 8; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic run(int id, int n_edges);
    logic acc, v;
    logic [7:0] d;
    upq.delete();
    pend_left = 0;
    check_recs(id, 0);
    for (int e = 1; e <= n_edges; e++) begin
      foreach (vecs[i])
        if (vecs[i].run == id && vecs[i].edge_no == e && vecs[i].kind == K_PUSH)
          upq.push_back(vecs[i].val);
      v = (upq.size() != 0);
      d = v ? upq[0] : 8'h00;
      tick(v, d, acc);
      if (acc) void'(upq.pop_front());
      check_recs(id, e);
      if (pend_left > 0) begin
        chk("tbl_line_bit", {7'd0, data_out}, {7'd0, pend_byte[pend_left-1]});
        pend_left--;
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    // Run 0: training, prefill to full, held byte, lone byte, push on a load edge.
    add(0, 0, K_RDY, 8'h01);  add(0, 0, K_ACT, 8'h00);
    add(0, 1, K_BYTE, IDLE);  add(0, 9, K_BYTE, IDLE);   add(0, 25, K_BYTE, IDLE);
    add(0, 24, K_ACT, 8'h00); add(0, 25, K_ACT, 8'h01);
    add(0, 2, K_PUSH, 8'h11); add(0, 2, K_PUSH, 8'h22);  add(0, 2, K_PUSH, 8'h33);
    add(0, 2, K_PUSH, 8'h44); add(0, 2, K_PUSH, 8'h55);
    add(0, 4, K_RDY, 8'h01);  add(0, 5, K_RDY, 8'h00);   add(0, 32, K_RDY, 8'h00);
    add(0, 33, K_RDY, 8'h01); add(0, 34, K_RDY, 8'h00);  add(0, 41, K_RDY, 8'h01);
    add(0, 33, K_BYTE, 8'h11); add(0, 41, K_BYTE, 8'h22); add(0, 49, K_BYTE, 8'h33);
    add(0, 57, K_BYTE, 8'h44); add(0, 65, K_BYTE, 8'h55); add(0, 73, K_BYTE, IDLE);
    add(0, 80, K_PUSH, 8'hA5); add(0, 81, K_BYTE, 8'hA5); add(0, 89, K_BYTE, IDLE);
    add(0, 89, K_PUSH, 8'h0F); add(0, 97, K_BYTE, 8'h0F);
    // Run 1: single byte in ACTIVE, then a push exactly on load edge 49.
    add(1, 33, K_BYTE, IDLE);  add(1, 40, K_PUSH, 8'hA5); add(1, 41, K_BYTE, 8'hA5);
    add(1, 49, K_PUSH, 8'h0F); add(1, 49, K_BYTE, IDLE);  add(1, 57, K_BYTE, 8'h0F);
    add(1, 65, K_BYTE, IDLE);
    // Run 2 queues bytes before a mid-byte reset; run 3 checks they were discarded.
    add(2, 40, K_PUSH, 8'h77); add(2, 42, K_PUSH, 8'h66); add(2, 41, K_BYTE, 8'h77);
    add(3, 0, K_RDY, 8'h01);  add(3, 0, K_ACT, 8'h00);   add(3, 1, K_BYTE, IDLE);
    add(3, 25, K_BYTE, IDLE); add(3, 25, K_ACT, 8'h01);  add(3, 33, K_BYTE, IDLE);
    add(3, 33, K_RDY, 8'h01); add(3, 41, K_BYTE, IDLE);

    do_reset();
    run(0, 106);
    do_reset();
    run(1, 72);
    do_reset();
    run(2, 44);

    // Asynchronous reset in the middle of a byte (between edges 44 and 45).
    #2;
    reset_L = 1'b0;
    #1;
    chk("midrst_data_out", {7'd0, data_out}, 8'h00);
    chk("midrst_ready_out", {7'd0, ready_out}, 8'h00);
    chk("midrst_active_out", {7'd0, active_out}, 8'h00);
    do_reset();
    run(3, 48);

    // Random traffic in phases of light, medium and heavy offered load.
    do_reset();
    for (int i = 0; i < 1800; i++) begin
      int         pct;
      logic       v, acc;
      logic [7:0] d;
      pct = ((i / 200) % 3 == 0) ? 15 : (((i / 200) % 3 == 1) ? 55 : 95);
      v   = ($urandom_range(99) < pct);
      d   = 8'($urandom);
      tick(v, d, acc);
    end
    valid_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
